// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program-counter owner and fetch control FSM.
// Selects a program base on Start, then steps, branches, stalls or halts the
// PC that addresses the instruction ROM. All outputs are registered.
// Optional build macro: FETCH_CYCLE_COUNT_EN adds the CycleCnt output, a
// saturating count of non-stalled RUN edges.
module fetch_sequencer #(
    parameter int PC_W       = 11,
    parameter int OFF_W      = 8,
    parameter int PROG0_BASE = 0,
    parameter int PROG1_BASE = 256,
    parameter int PROG2_BASE = 512
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       ProgSel,
    input  logic             Halt,
    input  logic             BrFwd,
    input  logic             BrBwd,
    input  logic [OFF_W-1:0] Target,
    input  logic             Stall,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             FetchValid,
    output logic             Done,
    output logic             BrErr
`ifdef FETCH_CYCLE_COUNT_EN
    ,
    output logic [15:0]      CycleCnt
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        RUN    = 2'd2,
        HALTED = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic              done_q, done_d;
    logic              br_err_q, br_err_d;
    logic [PC_W-1:0]   target_ext;
    logic [PC_W-1:0]   base_sel;

    // Map a program index to its start address; index 3 falls back to program 0.
    function automatic logic [PC_W-1:0] base_addr(input logic [1:0] sel);
        case (sel)
            2'd1:    return PC_W'(PROG1_BASE);
            2'd2:    return PC_W'(PROG2_BASE);
            default: return PC_W'(PROG0_BASE);
        endcase
    endfunction

    // Branch offsets are unsigned magnitudes; direction comes from BrFwd/BrBwd.
    assign target_ext = PC_W'(Target);
    assign base_sel   = base_addr(ProgSel);

    // Next-state, next-PC and sticky error computation for every state.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and no latch is inferred.
        state_d  = state_q;
        pc_d     = pc_q;
        br_err_d = br_err_q;

        case (state_q)
            IDLE: begin
                pc_d = '0;
                if (Start) begin
                    state_d  = ARMED;
                    pc_d     = base_sel;
                    br_err_d = 1'b0;
                end
            end

            ARMED: begin
                // The last ProgSel seen while Start is held wins.
                if (Start) begin
                    pc_d = base_sel;
                end else begin
                    state_d = RUN;
                end
            end

            RUN: begin
                if (Start) begin
                    // Restart abandons the current program; BrErr is kept.
                    state_d = ARMED;
                    pc_d    = base_sel;
                end else if (Stall) begin
                    pc_d = pc_q;
                end else if (Halt) begin
                    state_d = HALTED;
                end else if (BrFwd && BrBwd) begin
                    pc_d     = pc_q + PC_W'(1);
                    br_err_d = 1'b1;
                end else if (BrFwd) begin
                    pc_d = pc_q + target_ext;
                end else if (BrBwd) begin
                    pc_d = pc_q - target_ext;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end

            HALTED: begin
                if (Start) begin
                    state_d  = ARMED;
                    pc_d     = base_sel;
                    br_err_d = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
                pc_d    = '0;
            end
        endcase

        // Status flags are registered versions of the next state.
        fetch_valid_d = (state_d == RUN);
        done_d        = (state_d == HALTED);
    end

`ifdef FETCH_CYCLE_COUNT_EN
    logic [15:0] cyc_cnt_q, cyc_cnt_d;

    // Count productive RUN edges; clear on entry to ARMED, saturate at all-ones.
    always_comb begin
        cyc_cnt_d = cyc_cnt_q;
        if (state_d == ARMED) begin
            cyc_cnt_d = '0;
        end else if ((state_q == RUN) && !Stall && (cyc_cnt_q != 16'hFFFF)) begin
            cyc_cnt_d = cyc_cnt_q + 16'd1;
        end
    end

    // Cycle counter register with synchronous reset.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            cyc_cnt_q <= '0;
        end else begin
            cyc_cnt_q <= cyc_cnt_d;
        end
    end

    assign CycleCnt = cyc_cnt_q;
`endif

    // State and output registers; reset is sampled on the clock edge.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!Reset) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            fetch_valid_q <= 1'b0;
            done_q        <= 1'b0;
            br_err_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            done_q        <= done_d;
            br_err_q      <= br_err_d;
        end
    end

    assign ProgCtr    = pc_q;
    assign FetchValid = fetch_valid_q;
    assign Done       = done_q;
    assign BrErr      = br_err_q;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Control FSM that owns the program counter and sequences the fetch datapath across the three packed programs.
- Selects each program's base address on Start and holds the PC while Start is asserted.
- Steps, branches (forward/backward relative) or stalls the PC while running.
- Freezes the PC on Halt and reports Done to the testbench; sits between the decoder/ALU branch outputs and instruction ROM address.

Parameters:
PC_W, 11, program counter width
OFF_W, 8, branch offset width (unsigned magnitude)
PROG0_BASE, 0, start address of program 0
PROG1_BASE, 256, start address of program 1
PROG2_BASE, 512, start address of program 2

Ports:
Clk  input  1  clock; all state changes on rising edge
Reset  input  1  synchronous, active-low reset
Start  input  1  hold-to-arm; PC runs from base after falling edge
ProgSel  input  2  program index sampled while Start=1 (0..2)
Halt  input  1  decoder halt request (done instruction)
BrFwd  input  1  taken forward branch: PC <- PC + Target
BrBwd  input  1  taken backward branch: PC <- PC - Target
Target  input  OFF_W  branch offset magnitude
Stall  input  1  hold PC this cycle
ProgCtr  output  PC_W  instruction ROM address (registered)
FetchValid  output  1  ProgCtr addresses a live instruction (state RUN)
Done  output  1  program halted; level until next Start
BrErr  output  1  sticky: BrFwd and BrBwd seen together in RUN

Behaviour:
- Reset=0 at a clock edge: state IDLE; ProgCtr=0, FetchValid=0, Done=0, BrErr=0. Reset overrides everything, including mid-program.
- States: IDLE, ARMED, RUN, HALTED (2-bit encoded).
- IDLE:
  - Start=1 -> ARMED; ProgCtr <= base(ProgSel).
  - Otherwise hold, ProgCtr=0.
- ARMED:
  - ProgCtr reloaded every cycle with base(ProgSel), so the last ProgSel before Start falls wins.
  - FetchValid=0, Done=0.
  - Start=0 -> RUN; ProgCtr holds the base, so the first fetched instruction is the base address.
- base(): ProgSel 0/1/2 -> PROG0/1/2_BASE; ProgSel=3 -> PROG0_BASE.
- RUN, FetchValid=1. Per-edge priority, highest first:
  1. Start=1 -> ARMED, ProgCtr <= base(ProgSel); restart abandons the current program.
  2. Stall=1 -> ProgCtr holds; Halt and branches are ignored and must be re-presented by the requester.
  3. Halt=1 -> HALTED; ProgCtr holds at the halt address.
  4. BrFwd=1 and BrBwd=1 -> treated as no branch (PC+1); BrErr <= 1.
  5. BrFwd=1 -> PC + zero-extended Target.
  6. BrBwd=1 -> PC - zero-extended Target.
  7. Otherwise PC + 1.
- Arithmetic is modulo 2^PC_W; wrap is silent (2047+1 -> 0; 3-5 -> 2046). Target=0 branch holds PC (tight loop).
- HALTED:
  - Done=1, FetchValid=0, ProgCtr frozen.
  - Start=1 -> ARMED, Done <= 0 on that edge.
  - Halt, branch and Stall inputs are ignored.
- BrErr: sticky; cleared only by reset or by the IDLE/HALTED -> ARMED transition.
- Latency: one edge from any request to the ProgCtr update. All outputs are registered; no combinational input-to-output paths.

Optional Feature:
- Macro: FETCH_CYCLE_COUNT_EN.
- When defined: adds output CycleCnt[15:0], counting edges spent in RUN with Stall=0.
  - Cleared on reset and on entry to ARMED.
  - Saturates at 16'hFFFF.
  - Frozen (readable) in HALTED.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset=0 for 2 cycles with Start=1, BrFwd=1 -> ProgCtr=0, FetchValid=0, Done=0, BrErr=0. Then Reset=1 with Start=1, ProgSel=1 -> ARMED, ProgCtr=256.
- Start=1 with ProgSel=2, 3 cycles, then Start=0; 4 idle edges -> ProgCtr 512,513,514,515,516, FetchValid=1 from the first RUN cycle.
- RUN at PC=20: BrFwd with Target=10 -> 30; next edge BrBwd with Target=25 -> 5; at PC=3, BrBwd with Target=5 -> 2046. At PC=2047, plain step -> 0.
- RUN at PC=40: Stall=1 with Halt=1 -> PC stays 40, no Done. Next edge Stall=0, Halt=1 -> HALTED, Done=1, PC 40 frozen for 5 cycles despite BrFwd toggling.
- RUN at PC=60: BrFwd=BrBwd=1 -> PC=61, BrErr=1 and stays 1 after halt. Start from HALTED with ProgSel=0 -> ProgCtr=0, Done=0, BrErr=0.
- With FETCH_CYCLE_COUNT_EN: run 10 edges including 3 stalled, then halt -> CycleCnt=7 and held. Mid-run Start -> CycleCnt=0.
